// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle for axi_sram_slave: AW/W/B/AR/R channels with slave and
// master views. ID_WIDTH must match the ID_WIDTH of the attached slave.
interface axi_sram_slave_if #(
    parameter int ID_WIDTH = 8
);
    logic [ID_WIDTH-1:0] s_axi_awid;
    logic [35:0]         s_axi_awaddr;
    logic [7:0]          s_axi_awlen;
    logic [2:0]          s_axi_awsize;
    logic [1:0]          s_axi_awburst;
    logic                s_axi_awlock;
    logic [3:0]          s_axi_awcache;
    logic [2:0]          s_axi_awprot;
    logic [3:0]          s_axi_awqos;
    logic                s_axi_awvalid;
    logic                s_axi_awready;

    logic [63:0]         s_axi_wdata;
    logic [7:0]          s_axi_wstrb;
    logic                s_axi_wlast;
    logic                s_axi_wvalid;
    logic                s_axi_wready;

    logic [ID_WIDTH-1:0] s_axi_bid;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;

    logic [ID_WIDTH-1:0] s_axi_arid;
    logic [35:0]         s_axi_araddr;
    logic [7:0]          s_axi_arlen;
    logic [2:0]          s_axi_arsize;
    logic [1:0]          s_axi_arburst;
    logic                s_axi_arlock;
    logic [3:0]          s_axi_arcache;
    logic [2:0]          s_axi_arprot;
    logic [3:0]          s_axi_arqos;
    logic                s_axi_arvalid;
    logic                s_axi_arready;

    logic [ID_WIDTH-1:0] s_axi_rid;
    logic [63:0]         s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rlast;
    logic                s_axi_rvalid;
    logic                s_axi_rready;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
               s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
               s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of a 64-bit wide SRAM of 2^MEM_AW words.
// Independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) FSMs,
// FIXED/INCR/WRAP bursts, byte strobes, all outputs registered.
// Optional macro AXI_SRAM_ADDR_CHECK_EN: decode check on AW/AR addresses;
// failing bursts answer DECERR without touching memory.
module axi_sram_slave #(
    parameter int ID_WIDTH = 8,
    parameter int MEM_AW   = 12
) (
    input  logic            aclk,
    input  logic            aresetn,
    axi_sram_slave_if.slave s_axi
);
    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Next word index for a burst; WRAP only for 2/4/8/16 beats, otherwise INCR.
    function automatic logic [MEM_AW-1:0] next_index(
        input logic [MEM_AW-1:0] idx,
        input logic [7:0]        len,
        input logic [1:0]        burst
    );
        logic [MEM_AW-1:0] inc_v;
        logic [MEM_AW-1:0] mask_v;
        inc_v  = idx + MEM_AW'(1);
        mask_v = MEM_AW'(len);
        case (burst)
            2'b00: next_index = idx;
            2'b10: begin
                if ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)) begin
                    next_index = (idx & ~mask_v) | (inc_v & mask_v);
                end else begin
                    next_index = inc_v;
                end
            end
            default: next_index = inc_v;
        endcase
    endfunction

    logic [63:0] mem [DEPTH];

    // write side
    w_state_t            w_state_r;
    w_state_t            w_state_next_s;
    logic                awready_r;
    logic                wready_r;
    logic                bvalid_r;
    logic [ID_WIDTH-1:0] bid_r;
    logic [1:0]          bresp_r;
    logic [MEM_AW-1:0]   w_idx_r;
    logic [7:0]          w_len_r;
    logic [1:0]          w_burst_r;
    logic [7:0]          w_cnt_r;
    logic                w_done_r;
    logic                w_err_r;
    logic                aw_hs_s;
    logic                w_hs_s;
    logic                b_hs_s;
    logic                we_s;
    logic                aw_ok_s;
    logic [MEM_AW-1:0]   aw_idx_s;

    // read side
    r_state_t            r_state_r;
    r_state_t            r_state_next_s;
    logic                arready_r;
    logic                rvalid_r;
    logic                rlast_r;
    logic [ID_WIDTH-1:0] rid_r;
    logic [1:0]          rresp_r;
    logic [63:0]         rdata_r;
    logic [MEM_AW-1:0]   r_idx_r;
    logic [7:0]          r_len_r;
    logic [1:0]          r_burst_r;
    logic [7:0]          r_cnt_r;
    logic                r_err_r;
    logic                ar_hs_s;
    logic                r_hs_s;
    logic                ar_ok_s;
    logic [MEM_AW-1:0]   ar_idx_s;
    logic [MEM_AW-1:0]   r_idx_next_s;

    // sideband fields the slave does not act on
    logic                unused_ok_s;

    assign aw_idx_s     = s_axi.s_axi_awaddr[MEM_AW+2:3];
    assign ar_idx_s     = s_axi.s_axi_araddr[MEM_AW+2:3];
    assign aw_hs_s      = s_axi.s_axi_awvalid && awready_r;
    assign w_hs_s       = s_axi.s_axi_wvalid && wready_r;
    assign b_hs_s       = bvalid_r && s_axi.s_axi_bready;
    assign we_s         = w_hs_s && !w_done_r && !w_err_r;
    assign ar_hs_s      = s_axi.s_axi_arvalid && arready_r;
    assign r_hs_s       = rvalid_r && s_axi.s_axi_rready;
    assign r_idx_next_s = next_index(r_idx_r, r_len_r, r_burst_r);

`ifdef AXI_SRAM_ADDR_CHECK_EN
    assign aw_ok_s = (s_axi.s_axi_awaddr[35:30] == 6'b000001) &&
                     (s_axi.s_axi_awaddr[29:MEM_AW+3] == {(27-MEM_AW){1'b0}});
    assign ar_ok_s = (s_axi.s_axi_araddr[35:30] == 6'b000001) &&
                     (s_axi.s_axi_araddr[29:MEM_AW+3] == {(27-MEM_AW){1'b0}});
`else
    assign aw_ok_s = 1'b1;
    assign ar_ok_s = 1'b1;
`endif

    assign unused_ok_s = ^{s_axi.s_axi_awaddr, s_axi.s_axi_awsize, s_axi.s_axi_awlock,
                           s_axi.s_axi_awcache, s_axi.s_axi_awprot, s_axi.s_axi_awqos,
                           s_axi.s_axi_araddr, s_axi.s_axi_arsize, s_axi.s_axi_arlock,
                           s_axi.s_axi_arcache, s_axi.s_axi_arprot, s_axi.s_axi_arqos};

    // Write FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_r <= W_IDLE;
        end else begin
            w_state_r <= w_state_next_s;
        end
    end

    // Write FSM next-state: address, then data until wlast, then response.
    always_comb begin
        w_state_next_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s) w_state_next_s = W_DATA;
                else         w_state_next_s = W_IDLE;
            end
            W_DATA: begin
                if (w_hs_s && s_axi.s_axi_wlast) w_state_next_s = W_RESP;
                else                             w_state_next_s = W_DATA;
            end
            W_RESP: begin
                if (b_hs_s) w_state_next_s = W_IDLE;
                else        w_state_next_s = W_RESP;
            end
            default: w_state_next_s = W_IDLE;
        endcase
    end

    // Write channel outputs and burst bookkeeping; ready/valid follow the next state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= {ID_WIDTH{1'b0}};
            bresp_r   <= 2'b00;
            w_idx_r   <= {MEM_AW{1'b0}};
            w_len_r   <= 8'd0;
            w_burst_r <= 2'b00;
            w_cnt_r   <= 8'd0;
            w_done_r  <= 1'b0;
            w_err_r   <= 1'b0;
        end else begin
            awready_r <= (w_state_next_s == W_IDLE);
            wready_r  <= (w_state_next_s == W_DATA);
            bvalid_r  <= (w_state_next_s == W_RESP);
            if (aw_hs_s) begin
                bid_r     <= s_axi.s_axi_awid;
                bresp_r   <= aw_ok_s ? 2'b00 : 2'b11;
                w_idx_r   <= aw_idx_s;
                w_len_r   <= s_axi.s_axi_awlen;
                w_burst_r <= s_axi.s_axi_awburst;
                w_cnt_r   <= 8'd0;
                w_done_r  <= 1'b0;
                w_err_r   <= !aw_ok_s;
            end else if (w_hs_s) begin
                w_idx_r <= next_index(w_idx_r, w_len_r, w_burst_r);
                // beats past len+1 are swallowed once the burst is complete
                if (w_cnt_r == w_len_r) begin
                    w_done_r <= 1'b1;
                end else begin
                    w_cnt_r <= w_cnt_r + 8'd1;
                end
            end
        end
    end

    // Memory array write with per-byte strobes; contents survive reset.
    always_ff @(posedge aclk) begin
        if (we_s) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi.s_axi_wstrb[b]) begin
                    mem[w_idx_r][8*b +: 8] <= s_axi.s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_r <= R_IDLE;
        end else begin
            r_state_r <= r_state_next_s;
        end
    end

    // Read FSM next-state: stream beats until the rlast beat is accepted.
    always_comb begin
        r_state_next_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) r_state_next_s = R_DATA;
                else         r_state_next_s = R_IDLE;
            end
            R_DATA: begin
                if (r_hs_s && rlast_r) r_state_next_s = R_IDLE;
                else                   r_state_next_s = R_DATA;
            end
            default: r_state_next_s = R_IDLE;
        endcase
    end

    // Read channel outputs; rdata reloads on each accepted non-last beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rid_r     <= {ID_WIDTH{1'b0}};
            rresp_r   <= 2'b00;
            rdata_r   <= 64'd0;
            r_idx_r   <= {MEM_AW{1'b0}};
            r_len_r   <= 8'd0;
            r_burst_r <= 2'b00;
            r_cnt_r   <= 8'd0;
            r_err_r   <= 1'b0;
        end else begin
            arready_r <= (r_state_next_s == R_IDLE);
            rvalid_r  <= (r_state_next_s == R_DATA);
            if (ar_hs_s) begin
                rid_r     <= s_axi.s_axi_arid;
                rresp_r   <= ar_ok_s ? 2'b00 : 2'b11;
                rdata_r   <= ar_ok_s ? mem[ar_idx_s] : 64'd0;
                rlast_r   <= (s_axi.s_axi_arlen == 8'd0);
                r_idx_r   <= ar_idx_s;
                r_len_r   <= s_axi.s_axi_arlen;
                r_burst_r <= s_axi.s_axi_arburst;
                r_cnt_r   <= 8'd0;
                r_err_r   <= !ar_ok_s;
            end else if (r_hs_s) begin
                if (rlast_r) begin
                    rlast_r <= 1'b0;
                end else begin
                    r_idx_r <= r_idx_next_s;
                    r_cnt_r <= r_cnt_r + 8'd1;
                    rlast_r <= ((r_cnt_r + 8'd1) == r_len_r);
                    rdata_r <= r_err_r ? 64'd0 : mem[r_idx_next_s];
                end
            end
        end
    end

    assign s_axi.s_axi_awready = awready_r;
    assign s_axi.s_axi_wready  = wready_r;
    assign s_axi.s_axi_bid     = bid_r;
    assign s_axi.s_axi_bresp   = bresp_r;
    assign s_axi.s_axi_bvalid  = bvalid_r;
    assign s_axi.s_axi_arready = arready_r;
    assign s_axi.s_axi_rid     = rid_r;
    assign s_axi.s_axi_rdata   = rdata_r;
    assign s_axi.s_axi_rresp   = rresp_r;
    assign s_axi.s_axi_rlast   = rlast_r;
    assign s_axi.s_axi_rvalid  = rvalid_r;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed scenarios plus random
// bursts checked against a word-array reference model.
`timescale 1ns/1ps
module tb_axi_sram_slave;
    localparam int IDW   = 8;
    localparam int AW    = 12;
    localparam int LIMIT = 50;

    logic aclk = 1'b0;
    logic aresetn;

    always #5 aclk = ~aclk;

    axi_sram_slave_if #(.ID_WIDTH(IDW)) bus ();

    axi_sram_slave #(.ID_WIDTH(IDW), .MEM_AW(AW)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axi   (bus)
    );

    int total  = 0;
    int passed = 0;

    logic [63:0] model [0:4095];
    logic [63:0] wbuf  [0:299];
    logic [7:0]  sbuf  [0:299];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Word touched by beat i of a burst, from the AXI address rules.
    function automatic int beat_index(input int start, input int len, input int burst, input int i);
        int n;
        int base;
        n = len + 1;
        if (burst == 0) return start;
        if (burst == 2 && (n == 2 || n == 4 || n == 8 || n == 16)) begin
            base = (start / n) * n;
            return base + ((start - base + i) % n);
        end
        return (start + i) % 4096;
    endfunction

    function automatic logic [35:0] addr_of(input int idx);
        logic [35:0] a;
        logic [2:0]  lo;
        a = 36'h0_4000_0000;
        a[14:3] = idx[11:0];
        lo = 3'($urandom_range(0, 7));
        a[2:0] = lo;
        return a;
    endfunction

    task automatic do_write(input logic [IDW-1:0] id, input logic [35:0] addr, input int len,
                            input logic [1:0] burst, input int extra, input int bdelay,
                            input logic [1:0] exp_resp, input string tag);
        int n;
        int start;
        int w;
        bit stable;
        logic [IDW-1:0] held_id;
        start = int'(addr[14:3]);
        @(negedge aclk);
        bus.s_axi_awid    = id;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_awlen   = len[7:0];
        bus.s_axi_awburst = burst;
        bus.s_axi_awsize  = 3'd3;
        bus.s_axi_awvalid = 1'b1;
        n = 0;
        while (!bus.s_axi_awready && n < LIMIT) begin @(negedge aclk); n++; end
        check({tag, "_aw_timeout"}, 64'(n < LIMIT), 64'd1);
        @(negedge aclk);
        bus.s_axi_awvalid = 1'b0;
        for (int i = 0; i <= len + extra; i++) begin
            bus.s_axi_wdata  = wbuf[i];
            bus.s_axi_wstrb  = sbuf[i];
            bus.s_axi_wlast  = (i == len + extra);
            bus.s_axi_wvalid = 1'b1;
            n = 0;
            while (!bus.s_axi_wready && n < LIMIT) begin @(negedge aclk); n++; end
            if (n >= LIMIT) check($sformatf("%s_w_timeout%0d", tag, i), 64'd0, 64'd1);
            if (exp_resp == 2'b00 && i <= len) begin
                w = beat_index(start, len, int'(burst), i);
                for (int b = 0; b < 8; b++)
                    if (sbuf[i][b]) model[w][8*b +: 8] = wbuf[i][8*b +: 8];
            end
            @(negedge aclk);
        end
        bus.s_axi_wvalid = 1'b0;
        bus.s_axi_wlast  = 1'b0;
        n = 0;
        while (!bus.s_axi_bvalid && n < LIMIT) begin @(negedge aclk); n++; end
        check({tag, "_b_timeout"}, 64'(n < LIMIT), 64'd1);
        held_id = bus.s_axi_bid;
        stable  = 1'b1;
        repeat (bdelay) begin
            @(negedge aclk);
            if (!bus.s_axi_bvalid || bus.s_axi_bid !== held_id) stable = 1'b0;
        end
        if (bdelay > 0) check({tag, "_b_stable"}, 64'(stable), 64'd1);
        check({tag, "_bid"}, 64'(bus.s_axi_bid), 64'(id));
        check({tag, "_bresp"}, 64'(bus.s_axi_bresp), 64'(exp_resp));
        bus.s_axi_bready = 1'b1;
        @(negedge aclk);
        bus.s_axi_bready = 1'b0;
        check({tag, "_bvalid_drop"}, 64'(bus.s_axi_bvalid), 64'd0);
    endtask

    // mode 0: rready always 1, 1: toggling, 2: random
    task automatic do_read(input logic [IDW-1:0] id, input logic [35:0] addr, input int len,
                           input logic [1:0] burst, input int mode, input bit exp_err,
                           input string tag);
        int n;
        int got;
        int start;
        bit stable;
        bit have_prev;
        logic [63:0] prev_data;
        logic        prev_last;
        logic [63:0] exp;
        start = int'(addr[14:3]);
        @(negedge aclk);
        bus.s_axi_arid    = id;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arlen   = len[7:0];
        bus.s_axi_arburst = burst;
        bus.s_axi_arsize  = 3'd3;
        bus.s_axi_arvalid = 1'b1;
        n = 0;
        while (!bus.s_axi_arready && n < LIMIT) begin @(negedge aclk); n++; end
        check({tag, "_ar_timeout"}, 64'(n < LIMIT), 64'd1);
        @(negedge aclk);
        bus.s_axi_arvalid = 1'b0;
        got = 0; n = 0; stable = 1'b1; have_prev = 1'b0;
        prev_data = 64'd0; prev_last = 1'b0;
        while (got <= len && n < 2000) begin
            case (mode)
                0:       bus.s_axi_rready = 1'b1;
                1:       bus.s_axi_rready = (n % 2 == 0);
                default: bus.s_axi_rready = 1'($urandom_range(0, 1));
            endcase
            if (bus.s_axi_rvalid) begin
                if (have_prev && (bus.s_axi_rdata !== prev_data || bus.s_axi_rlast !== prev_last))
                    stable = 1'b0;
                if (bus.s_axi_rready) begin
                    exp = exp_err ? 64'd0 : model[beat_index(start, len, int'(burst), got)];
                    check($sformatf("%s_rdata%0d", tag, got), bus.s_axi_rdata, exp);
                    check($sformatf("%s_rlast%0d", tag, got), 64'(bus.s_axi_rlast), 64'(got == len));
                    check($sformatf("%s_rresp%0d", tag, got), 64'(bus.s_axi_rresp),
                          exp_err ? 64'd3 : 64'd0);
                    check($sformatf("%s_rid%0d", tag, got), 64'(bus.s_axi_rid), 64'(id));
                    got++;
                    have_prev = 1'b0;
                end else begin
                    have_prev = 1'b1;
                    prev_data = bus.s_axi_rdata;
                    prev_last = bus.s_axi_rlast;
                end
            end
            @(negedge aclk);
            n++;
        end
        bus.s_axi_rready = 1'b0;
        check({tag, "_beats"}, 64'(got), 64'(len + 1));
        if (mode != 0) check({tag, "_r_stable"}, 64'(stable), 64'd1);
        check({tag, "_rvalid_drop"}, 64'(bus.s_axi_rvalid), 64'd0);
    endtask

    initial begin
        int n;
        int start;
        int len;
        int burst;
        bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = '0;
        bus.s_axi_awburst = '0; bus.s_axi_awlock = '0; bus.s_axi_awcache = '0;
        bus.s_axi_awprot = '0; bus.s_axi_awqos = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = '0;
        bus.s_axi_arburst = '0; bus.s_axi_arlock = '0; bus.s_axi_arcache = '0;
        bus.s_axi_arprot = '0; bus.s_axi_arqos = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b0;

        // reset state
        aresetn = 1'b0;
        #12;
        check("rst_awready", 64'(bus.s_axi_awready), 64'd1);
        check("rst_arready", 64'(bus.s_axi_arready), 64'd1);
        check("rst_wready",  64'(bus.s_axi_wready),  64'd0);
        check("rst_bvalid",  64'(bus.s_axi_bvalid),  64'd0);
        check("rst_rvalid",  64'(bus.s_axi_rvalid),  64'd0);
        check("rst_rlast",   64'(bus.s_axi_rlast),   64'd0);
        check("rst_ids",     64'({bus.s_axi_bid, bus.s_axi_rid}), 64'd0);
        check("rst_resps",   64'({bus.s_axi_bresp, bus.s_axi_rresp}), 64'd0);
        check("rst_rdata",   bus.s_axi_rdata, 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        // 256-beat INCR fill of words 0..255 and full read back
        for (int i = 0; i < 256; i++) begin
            wbuf[i] = {$urandom, $urandom};
            sbuf[i] = 8'hFF;
        end
        do_write(8'hA1, 36'h0_4000_0000, 255, 2'b01, 0, 0, 2'b00, "fill");
        do_read(8'hA2, 36'h0_4000_0000, 255, 2'b01, 0, 1'b0, "fill_rd");

        // INCR write/read of 0x11..0x44
        wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
        for (int i = 0; i < 4; i++) sbuf[i] = 8'hFF;
        do_write(8'h05, 36'h0_4000_0000, 3, 2'b01, 0, 0, 2'b00, "incr");
        do_read(8'h06, 36'h0_4000_0000, 3, 2'b01, 0, 1'b0, "incr_rd");

        // WRAP read from word 2: order 2,3,0,1
        do_read(8'h07, 36'h0_4000_0010, 3, 2'b10, 0, 1'b0, "wrap_rd");

        // strobe merge on word 5
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'hFF;
        do_write(8'h08, 36'h0_4000_0028, 0, 2'b01, 0, 0, 2'b00, "strb_a");
        wbuf[0] = 64'd0; sbuf[0] = 8'h0F;
        do_write(8'h09, 36'h0_4000_0028, 0, 2'b01, 0, 0, 2'b00, "strb_b");
        do_read(8'h0A, 36'h0_4000_0028, 0, 2'b01, 0, 1'b0, "strb_rd");

        // beats after len+1 are accepted but not written
        wbuf[0] = 64'hAAAA_0000_0000_00C8; wbuf[1] = 64'hBBBB_0000_0000_00C9;
        sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
        do_write(8'h0B, addr_of(200), 0, 2'b01, 1, 0, 2'b00, "extra");
        do_read(8'h0C, addr_of(200), 1, 2'b01, 0, 1'b0, "extra_rd");

        // backpressure: toggled rready on 16 beats, bready held off 10 cycles
        do_read(8'h0D, addr_of(16), 15, 2'b01, 1, 1'b0, "bp_rd");
        wbuf[0] = {$urandom, $urandom}; sbuf[0] = 8'hFF;
        do_write(8'h5E, addr_of(30), 0, 2'b01, 0, 10, 2'b00, "bp_wr");

        // reset during beat 2 of a 4-beat write
        wbuf[0] = 64'h1234_5678_9ABC_DEF0;
        @(negedge aclk);
        bus.s_axi_awid = 8'h33; bus.s_axi_awaddr = addr_of(40); bus.s_axi_awlen = 8'd3;
        bus.s_axi_awburst = 2'b01; bus.s_axi_awvalid = 1'b1;
        n = 0;
        while (!bus.s_axi_awready && n < LIMIT) begin @(negedge aclk); n++; end
        @(negedge aclk);
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = wbuf[0]; bus.s_axi_wstrb = 8'hFF; bus.s_axi_wvalid = 1'b1;
        n = 0;
        while (!bus.s_axi_wready && n < LIMIT) begin @(negedge aclk); n++; end
        check("mid_w_timeout", 64'(n < LIMIT), 64'd1);
        model[40] = wbuf[0];
        @(negedge aclk);
        bus.s_axi_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        aresetn = 1'b0;
        #1;
        check("mid_rst_awready", 64'(bus.s_axi_awready), 64'd1);
        check("mid_rst_wready",  64'(bus.s_axi_wready),  64'd0);
        bus.s_axi_wvalid = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        check("mid_rel_awready", 64'(bus.s_axi_awready), 64'd1);
        check("mid_rel_bvalid",  64'(bus.s_axi_bvalid),  64'd0);
        check("mid_rel_wready",  64'(bus.s_axi_wready),  64'd0);
        do_read(8'h34, addr_of(40), 1, 2'b01, 0, 1'b0, "mid_rd0");
        for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
        do_write(8'h35, addr_of(40), 3, 2'b01, 0, 0, 2'b00, "mid_wr");
        do_read(8'h36, addr_of(40), 3, 2'b01, 2, 1'b0, "mid_rd1");

        // random bursts confined to the initialised words 0..255
        for (int it = 0; it < 40; it++) begin
            start = $urandom_range(0, 127);
            burst = $urandom_range(0, 3);
            if (burst == 2 && $urandom_range(0, 3) != 0) len = (2 << $urandom_range(0, 3)) - 1;
            else len = $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) begin
                    wbuf[i] = {$urandom, $urandom};
                    sbuf[i] = 8'($urandom_range(0, 255));
                end
                do_write(8'($urandom), addr_of(start), len, 2'(burst), 0,
                         $urandom_range(0, 3), 2'b00, $sformatf("rnd%0d_wr", it));
            end else begin
                do_read(8'($urandom), addr_of(start), len, 2'(burst), 2, 1'b0,
                        $sformatf("rnd%0d_rd", it));
            end
        end

`ifdef AXI_SRAM_ADDR_CHECK_EN
        // out-of-range address: DECERR, zero data, memory untouched
        do_read(8'h71, 36'h0_8000_0000, 1, 2'b01, 0, 1'b1, "dec_rd");
        wbuf[0] = 64'h0BAD_0BAD_0BAD_0BAD; wbuf[1] = 64'h0BAD_0BAD_0BAD_0BAD;
        sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
        do_write(8'h72, 36'h0_8000_0000, 1, 2'b01, 0, 0, 2'b11, "dec_wr");
        do_read(8'h73, 36'h0_4000_0000, 1, 2'b01, 0, 1'b0, "dec_chk");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
